// File: rtl/student_fir_pkg.sv
// Shared types for the FIR sample history ring.
// Holds the ring FSM states and default ring geometry.
package student_fir_pkg;

  localparam int AddrWidth = 10;
  localparam int RingDepth = 2 ** AddrWidth;

  typedef logic [AddrWidth-1:0] tap_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    CLEAR
  } ring_state_e;

endpackage

// File: rtl/student_sample_ring_ctrl.sv
// Circular sample history controller: writes one sample, streams NumTaps taps.
// Optional STUDENT_SAMPLE_RING_CLEAR_EN zero-fills the ring after reset.
module student_sample_ring_ctrl #(
  parameter int AddrWidth = 10,
  parameter int DataSize  = 16,
  parameter int NumTaps   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataSize-1:0]  sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  output logic                 ram_ena_o,
  output logic                 ram_wea_o,
  output logic [AddrWidth-1:0] ram_addra_o,
  output logic [DataSize-1:0]  ram_dia_o,
  output logic                 ram_enb_o,
  output logic [AddrWidth-1:0] ram_addrb_o,
  input  logic [DataSize-1:0]  ram_dob_i,
  output logic [DataSize-1:0]  tap_data_o,
  output logic [AddrWidth-1:0] tap_idx_o,
  output logic                 tap_valid_o,
  output logic                 tap_first_o,
  output logic                 tap_last_o,
  output logic                 busy_o
);

  import student_fir_pkg::*;

  typedef logic [AddrWidth-1:0] addr_t;

  localparam addr_t LastTap = addr_t'(NumTaps - 1);

`ifdef STUDENT_SAMPLE_RING_CLEAR_EN
  localparam ring_state_e RstState = CLEAR;
`else
  localparam ring_state_e RstState = IDLE;
`endif

  if (NumTaps < 1 || NumTaps > 2 ** AddrWidth) begin : g_bad_taps
    $error("NumTaps must lie in 1..2**AddrWidth");
  end

  ring_state_e state_q, state_d;
  addr_t       wr_ptr_q, wr_ptr_d;
  addr_t       base_q, base_d;
  addr_t       rd_cnt_q, rd_cnt_d;
  logic        first_d, last_d;

  logic        tap_valid_q, tap_first_q, tap_last_q;
  addr_t       tap_idx_q;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    base_d         = base_q;
    rd_cnt_d       = rd_cnt_q;
    sample_ready_o = 1'b0;
    ram_ena_o      = 1'b0;
    ram_wea_o      = 1'b0;
    ram_addra_o    = '0;
    ram_dia_o      = '0;
    ram_enb_o      = 1'b0;
    ram_addrb_o    = '0;
    first_d        = 1'b0;
    last_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) begin
          ram_ena_o   = 1'b1;
          ram_wea_o   = 1'b1;
          ram_addra_o = wr_ptr_q;
          ram_dia_o   = sample_i;
          base_d      = wr_ptr_q;
          rd_cnt_d    = '0;
          state_d     = READ;
        end
      end
      READ: begin
        // Unsigned subtraction walks backwards through the ring.
        ram_enb_o   = 1'b1;
        ram_addrb_o = base_q - rd_cnt_q;
        first_d     = (rd_cnt_q == '0);
        last_d      = (rd_cnt_q == LastTap);
        if (last_d) begin
          state_d  = DRAIN;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      CLEAR: begin
`ifdef STUDENT_SAMPLE_RING_CLEAR_EN
        ram_ena_o   = 1'b1;
        ram_wea_o   = 1'b1;
        ram_addra_o = rd_cnt_q;
        rd_cnt_d    = rd_cnt_q + 1'b1;
        if (&rd_cnt_q) begin
          state_d  = IDLE;
          rd_cnt_d = '0;
        end
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RstState;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      rd_cnt_q    <= '0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      rd_cnt_q    <= rd_cnt_d;
      // Delay matches the RAM's registered read port.
      tap_valid_q <= ram_enb_o;
      tap_idx_q   <= ram_enb_o ? rd_cnt_q : '0;
      tap_first_q <= first_d;
      tap_last_q  <= last_d;
    end
  end

  assign tap_data_o  = tap_valid_q ? ram_dob_i : '0;
  assign tap_idx_o   = tap_idx_q;
  assign tap_valid_o = tap_valid_q;
  assign tap_first_o = tap_first_q;
  assign tap_last_o  = tap_last_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_student_sample_ring_ctrl.sv
// Scoreboard bench for student_sample_ring_ctrl with a behavioural ring model.
// Also exercises a NumTaps=1 instance and, when compiled in, the clear sweep.
module tb_student_sample_ring_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int NT    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] sample;
  logic          valid;
  logic          ready;
  logic          ena, wea, enb;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dia, dob;
  logic [DW-1:0] tdata;
  logic [AW-1:0] tidx;
  logic          tvalid, tfirst, tlast, busy;

  student_sample_ring_ctrl #(
    .AddrWidth(AW), .DataSize(DW), .NumTaps(NT)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .sample_i(sample), .sample_valid_i(valid), .sample_ready_o(ready),
    .ram_ena_o(ena), .ram_wea_o(wea), .ram_addra_o(addra), .ram_dia_o(dia),
    .ram_enb_o(enb), .ram_addrb_o(addrb), .ram_dob_i(dob),
    .tap_data_o(tdata), .tap_idx_o(tidx), .tap_valid_o(tvalid),
    .tap_first_o(tfirst), .tap_last_o(tlast), .busy_o(busy)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
    if (enb) dob <= mem[addrb];
  end

  logic [DW-1:0] sample1;
  logic          valid1, ready1;
  logic          ena1, wea1, enb1;
  logic [AW-1:0] addra1, addrb1, tidx1;
  logic [DW-1:0] dia1, dob1, tdata1;
  logic          tvalid1, tfirst1, tlast1, busy1;

  student_sample_ring_ctrl #(
    .AddrWidth(AW), .DataSize(DW), .NumTaps(1)
  ) u_one (
    .clk_i(clk), .rst_i(rst),
    .sample_i(sample1), .sample_valid_i(valid1), .sample_ready_o(ready1),
    .ram_ena_o(ena1), .ram_wea_o(wea1), .ram_addra_o(addra1),
    .ram_dia_o(dia1), .ram_enb_o(enb1), .ram_addrb_o(addrb1),
    .ram_dob_i(dob1), .tap_data_o(tdata1), .tap_idx_o(tidx1),
    .tap_valid_o(tvalid1), .tap_first_o(tfirst1), .tap_last_o(tlast1),
    .busy_o(busy1)
  );

  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (ena1 && wea1) mem1[addra1] <= dia1;
    if (enb1) dob1 <= mem1[addrb1];
  end

  typedef struct {
    logic [DW-1:0] d;
    int            k;
  } tap_t;

  logic [DW-1:0] ring [DEPTH];
  int            wp;
  tap_t          exp_q[$];
  int            addr_q[$];
  int            vectors;
  int            miscompares;
  int            cyc;
  int            last_acc;
  bit            thru_mode;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    tap_t t;
    int   idx;
    cyc++;
    if (!rst) begin
      if (enb) begin
        if (addr_q.size() == 0) chk("rd_addr_spurious", 1, 0);
        else chk("rd_addr", addrb, addr_q.pop_front());
      end
      if (tvalid) begin
        if (exp_q.size() == 0) begin
          chk("tap_spurious", 1, 0);
        end else begin
          t = exp_q.pop_front();
          chk("tap_data", tdata, t.d);
          chk("tap_idx", tidx, t.k);
          chk("tap_first", tfirst, t.k == 0);
          chk("tap_last", tlast, t.k == NT - 1);
        end
      end
      if (busy) chk("ready_while_busy", ready, 0);
      if (valid && ready) begin
        chk("wr_en", {ena, wea}, 2'b11);
        chk("wr_addr", addra, wp);
        chk("wr_data", dia, sample);
        ring[wp] = sample;
        for (int k = 0; k < NT; k++) begin
          idx = (wp - k + DEPTH) % DEPTH;
          exp_q.push_back('{ring[idx], k});
          addr_q.push_back(idx);
        end
        wp = (wp + 1) % DEPTH;
        if (thru_mode && last_acc >= 0)
          chk("accept_spacing", cyc - last_acc, NT + 2);
        last_acc = cyc;
      end
    end
  end

  task automatic push(logic [DW-1:0] v);
    int n;
    n = 0;
    sample = v;
    valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 100);
    if (!ready) chk("push_timeout", 1, 0);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int acc;
    int seen;
    int at;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    wp          = 0;
    last_acc    = -1;
    thru_mode   = 1'b0;
    valid       = 1'b0;
    sample      = '0;
    valid1      = 1'b0;
    sample1     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      mem1[i] = '0;
      ring[i] = '0;
    end
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tap_valid", tvalid, 0);
    chk("rst_enb", enb, 0);
    chk("rst_flags", {tfirst, tlast}, 0);
`ifdef STUDENT_SAMPLE_RING_CLEAR_EN
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 1);
`else
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ena", ena, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef STUDENT_SAMPLE_RING_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("clr_we", {ena, wea}, 2'b11);
      chk("clr_addr", addra, i);
      chk("clr_data", dia, 0);
      chk("clr_ready", ready, 0);
    end
    @(negedge clk);
    chk("clr_done_ready", ready, 1);
`endif

    push(16'h0011);
    wait_drain();

    for (int i = 1; i <= 10; i++) push(16'(i));
    wait_drain();

    thru_mode = 1'b1;
    last_acc  = -1;
    acc       = 0;
    sample    = 16'($urandom);
    valid     = 1'b1;
    for (int n = 0; n < 100 && acc < 5; n++) begin
      @(negedge clk);
      seen = int'(ready);
      @(posedge clk);
      #1;
      if (seen != 0) begin
        acc++;
        sample = 16'($urandom);
      end
    end
    valid     = 1'b0;
    chk("thru_accepts", acc, 5);
    wait_drain();
    thru_mode = 1'b0;

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 push(16'($urandom));
    end
    wait_drain();

    push(16'h1234);
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk);
      seen = int'(tvalid);
    end
    chk("mid_stream_seen", seen, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tap_valid", tvalid, 0);
`ifdef STUDENT_SAMPLE_RING_CLEAR_EN
    chk("mid_rst_ready", ready, 0);
    for (int i = 0; i < DEPTH; i++) ring[i] = '0;
`else
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_busy", busy, 0);
`endif
    exp_q.delete();
    addr_q.delete();
    wp = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    push(16'hBEEF);
    wait_drain();

    sample1 = 16'h5A5A;
    valid1  = 1'b1;
    at      = 0;
    for (int n = 0; n < 100 && at == 0; n++) begin
      @(negedge clk);
      if (ready1) at = 1;
    end
    chk("one_accept", at, 1);
    @(posedge clk);
    #1 valid1 = 1'b0;
    seen = 0;
    at   = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (tvalid1) begin
        seen++;
        at = n;
        chk("one_data", tdata1, 16'h5A5A);
        chk("one_idx", tidx1, 0);
        chk("one_flags", {tfirst1, tlast1}, 2'b11);
      end
    end
    chk("one_tap_count", seen, 1);
    chk("one_tap_latency", at, 2);

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
